// File: rtl/std_dffckpt_ber_pkg.sv
// std_dffckpt_ber_pkg
// Shared helpers for the checkpointed bit-enable register.
// Contents:
//   ckpt_idx_w() - slot index width for a given slot count. It never returns
//                  less than 1, so a single-slot bank still has an index port.
package std_dffckpt_ber_pkg;

    function automatic int ckpt_idx_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/std_dffckpt_slot.sv
// std_dffckpt_slot
// One checkpoint slot: a data register plus its valid flag.
// Ports:
//   clk, resetn - clock, synchronous active-low reset (resets the valid flag only)
//   save        - capture din and mark the slot valid
//   consume     - invalidate the slot (a restore read it in consume mode)
//   clear       - invalidate the slot (bank-wide clear)
//   din         - data to capture on save
//   data        - stored data (don't-care while the slot is invalid)
//   valid       - slot holds a checkpoint
module std_dffckpt_slot #(
    parameter int DFF_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 save,
    input  logic                 consume,
    input  logic                 clear,
    input  logic [DFF_WIDTH-1:0] din,
    output logic [DFF_WIDTH-1:0] data,
    output logic                 valid
);

    // Slot data has no reset; the valid flag qualifies it.
    always_ff @(posedge clk) begin
        if (save) begin
            data <= din;
        end
    end

    // Save wins over clear and consume: a slot written this cycle always ends
    // valid, which covers both the swap case and save-with-clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
        end else if (save) begin
            valid <= 1'b1;
        end else if (clear || consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/std_dffckpt_ber.sv
// std_dffckpt_ber
// Bit-enable register with a bank of checkpoint slots for speculative state.
// The live value q updates per bit; it can be saved into a slot and later
// restored from one to roll back.
// Ports:
//   clk, resetn                     - clock, synchronous active-low reset
//   en, d                           - per-bit write enable and write data
//   q                               - live register value
//   ckpt_save, ckpt_save_idx        - save pre-edge q into a slot
//   ckpt_restore, ckpt_restore_idx  - load q from a valid slot
//   ckpt_clear                      - invalidate all slots
//   ckpt_valid                      - per-slot valid flags
//   ckpt_err                        - one-cycle pulse after an illegal save/restore
module std_dffckpt_ber
    import std_dffckpt_ber_pkg::*;
#(
    parameter int                   DFF_WIDTH       = 1,
    parameter logic [DFF_WIDTH-1:0] DFF_RESET_VALUE = '0,
    parameter int                   CKPT_DEPTH      = 4,
    parameter int                   CKPT_CONSUME    = 0,
    localparam int                  CKPT_IDX_WIDTH  = ckpt_idx_w(CKPT_DEPTH)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [DFF_WIDTH-1:0]      en,
    input  logic [DFF_WIDTH-1:0]      d,
    output logic [DFF_WIDTH-1:0]      q,
    input  logic                      ckpt_save,
    input  logic [CKPT_IDX_WIDTH-1:0] ckpt_save_idx,
    input  logic                      ckpt_restore,
    input  logic [CKPT_IDX_WIDTH-1:0] ckpt_restore_idx,
    input  logic                      ckpt_clear,
    output logic [CKPT_DEPTH-1:0]     ckpt_valid,
    output logic                      ckpt_err
);

    logic [CKPT_DEPTH-1:0][DFF_WIDTH-1:0] slot_data;
    logic [CKPT_DEPTH-1:0]                save_vec;
    logic [CKPT_DEPTH-1:0]                consume_vec;
    logic                                 restore_hit;
    logic [DFF_WIDTH-1:0]                 restore_data;
    logic                                 restore_ok;
    logic                                 save_ill;
    logic                                 restore_ill;

    // Decode by comparing against every slot number rather than indexing, so
    // an out-of-range index simply matches nothing (non-power-of-two depth).
    always_comb begin
        save_vec     = '0;
        consume_vec  = '0;
        restore_hit  = 1'b0;
        restore_data = '0;
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            save_vec[i] = ckpt_save && (ckpt_save_idx == CKPT_IDX_WIDTH'(i));
            if (ckpt_restore_idx == CKPT_IDX_WIDTH'(i)) begin
                restore_hit  = ckpt_valid[i];
                restore_data = slot_data[i];
            end
        end
        restore_ok  = ckpt_restore && restore_hit;
        restore_ill = ckpt_restore && !restore_hit;
        save_ill    = ckpt_save && (save_vec == '0);
        for (int i = 0; i < CKPT_DEPTH; i++) begin
            consume_vec[i] = (CKPT_CONSUME != 0) && restore_ok &&
                             (ckpt_restore_idx == CKPT_IDX_WIDTH'(i));
        end
    end

    for (genvar g = 0; g < CKPT_DEPTH; g++) begin : g_slot
        std_dffckpt_slot #(
            .DFF_WIDTH(DFF_WIDTH)
        ) u_slot (
            .clk    (clk),
            .resetn (resetn),
            .save   (save_vec[g]),
            .consume(consume_vec[g]),
            .clear  (ckpt_clear),
            .din    (q),
            .data   (slot_data[g]),
            .valid  (ckpt_valid[g])
        );
    end

    // A legal restore overrides the per-bit write entirely; an illegal one
    // falls through to the normal write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= DFF_RESET_VALUE;
        end else if (restore_ok) begin
            q <= restore_data;
        end else begin
            q <= (q & ~en) | (d & en);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ckpt_err <= 1'b0;
        end else begin
            ckpt_err <= save_ill || restore_ill;
        end
    end

endmodule

// File: tb/tb_std_dffckpt_ber.sv
// tb_std_dffckpt_ber
// Directed bench for std_dffckpt_ber. Three instances share one stimulus:
//   a: depth 4, non-consuming   b: depth 4, consuming   c: depth 3, non-consuming
// All are 8 bits wide with reset value 0xA5.
module tb_std_dffckpt_ber;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] en, d;
    logic       ckpt_save, ckpt_restore, ckpt_clear;
    logic [1:0] ckpt_save_idx, ckpt_restore_idx;

    logic [7:0] q_a, q_b, q_c;
    logic [3:0] valid_a, valid_b;
    logic [2:0] valid_c;
    logic       err_a, err_b, err_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    std_dffckpt_ber #(.DFF_WIDTH(8), .DFF_RESET_VALUE(8'hA5), .CKPT_DEPTH(4), .CKPT_CONSUME(0)) dut_a (
        .clk(clk), .resetn(resetn), .en(en), .d(d), .q(q_a),
        .ckpt_save(ckpt_save), .ckpt_save_idx(ckpt_save_idx),
        .ckpt_restore(ckpt_restore), .ckpt_restore_idx(ckpt_restore_idx),
        .ckpt_clear(ckpt_clear), .ckpt_valid(valid_a), .ckpt_err(err_a));

    std_dffckpt_ber #(.DFF_WIDTH(8), .DFF_RESET_VALUE(8'hA5), .CKPT_DEPTH(4), .CKPT_CONSUME(1)) dut_b (
        .clk(clk), .resetn(resetn), .en(en), .d(d), .q(q_b),
        .ckpt_save(ckpt_save), .ckpt_save_idx(ckpt_save_idx),
        .ckpt_restore(ckpt_restore), .ckpt_restore_idx(ckpt_restore_idx),
        .ckpt_clear(ckpt_clear), .ckpt_valid(valid_b), .ckpt_err(err_b));

    std_dffckpt_ber #(.DFF_WIDTH(8), .DFF_RESET_VALUE(8'hA5), .CKPT_DEPTH(3), .CKPT_CONSUME(0)) dut_c (
        .clk(clk), .resetn(resetn), .en(en), .d(d), .q(q_c),
        .ckpt_save(ckpt_save), .ckpt_save_idx(ckpt_save_idx),
        .ckpt_restore(ckpt_restore), .ckpt_restore_idx(ckpt_restore_idx),
        .ckpt_clear(ckpt_clear), .ckpt_valid(valid_c), .ckpt_err(err_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 8'h00; d = 8'h00;
        ckpt_save = 1'b0; ckpt_save_idx = 2'd0;
        ckpt_restore = 1'b0; ckpt_restore_idx = 2'd0;
        ckpt_clear = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        tick(); tick();
        chk("reset_q_a", q_a, 8'hA5);
        chk("reset_valid_a", valid_a, 4'b0000);
        chk("reset_err_a", err_a, 1'b0);
        chk("reset_q_c", q_c, 8'hA5);

        // Bit write: low nibble only.
        resetn = 1'b1; en = 8'h0F; d = 8'hFF;
        tick();
        chk("bitwrite_q_a", q_a, 8'hAF);

        en = 8'hFF; d = 8'h12;
        tick();
        chk("write12_q_a", q_a, 8'h12);

        // Save slot 2 captures pre-edge q (0x12) while q takes 0x34.
        ckpt_save = 1'b1; ckpt_save_idx = 2'd2; en = 8'hFF; d = 8'h34;
        tick();
        chk("save2_q_a", q_a, 8'h34);
        chk("save2_valid_a", valid_a, 4'b0100);
        chk("save2_valid_c", valid_c, 3'b100);

        idle(); ckpt_restore = 1'b1; ckpt_restore_idx = 2'd2;
        tick();
        chk("restore2_q_a", q_a, 8'h12);
        chk("restore2_valid_a", valid_a, 4'b0100);
        chk("restore2_err_a", err_a, 1'b0);
        chk("restore2_valid_b_consumed", valid_b, 4'b0000);

        // Consume sequence on slot 1: slot1 = 0x12, q = 0x66.
        idle(); ckpt_save = 1'b1; ckpt_save_idx = 2'd1; en = 8'hFF; d = 8'h66;
        tick();
        chk("save1_q_b", q_b, 8'h66);
        chk("save1_valid_b", valid_b, 4'b0010);

        idle(); ckpt_restore = 1'b1; ckpt_restore_idx = 2'd1;
        tick();
        chk("restore1_q_b", q_b, 8'h12);
        chk("restore1_valid_b", valid_b, 4'b0000);
        chk("restore1_valid_a", valid_a, 4'b0110);

        // Second restore: illegal in consume mode, so the write lands.
        idle(); ckpt_restore = 1'b1; ckpt_restore_idx = 2'd1; en = 8'hFF; d = 8'h77;
        tick();
        chk("restore1b_q_b", q_b, 8'h77);
        chk("restore1b_err_b", err_b, 1'b1);
        chk("restore1b_q_a", q_a, 8'h12);
        chk("restore1b_err_a", err_a, 1'b0);

        idle();
        tick();
        chk("errpulse_b", err_b, 1'b0);
        chk("hold_q_b", q_b, 8'h77);

        // Index 3 is out of range only for the depth-3 instance.
        idle(); ckpt_save = 1'b1; ckpt_save_idx = 2'd3;
        tick();
        chk("oor_valid_c", valid_c, 3'b110);
        chk("oor_err_c", err_c, 1'b1);
        chk("save3_valid_a", valid_a, 4'b1110);
        chk("save3_err_a", err_a, 1'b0);

        idle();
        tick();
        chk("oor_errpulse_c", err_c, 1'b0);

        // Swap: slot0 = 0x55, q = 0xAA, then save+restore slot 0 with en all ones.
        idle(); en = 8'hFF; d = 8'h55;
        tick();
        idle(); ckpt_save = 1'b1; ckpt_save_idx = 2'd0; en = 8'hFF; d = 8'hAA;
        tick();
        chk("pre_swap_q_a", q_a, 8'hAA);
        chk("pre_swap_valid_b", valid_b, 4'b1001);
        idle(); ckpt_save = 1'b1; ckpt_save_idx = 2'd0;
        ckpt_restore = 1'b1; ckpt_restore_idx = 2'd0; en = 8'hFF; d = 8'h33;
        tick();
        chk("swap_q_a", q_a, 8'h55);
        chk("swap_valid_a", valid_a, 4'b1111);
        chk("swap_valid_b_kept", valid_b, 4'b1001);
        chk("swap_err_a", err_a, 1'b0);

        idle(); ckpt_restore = 1'b1; ckpt_restore_idx = 2'd0;
        tick();
        chk("after_swap_q_a", q_a, 8'hAA);
        chk("after_swap_q_b", q_b, 8'hAA);
        chk("after_swap_valid_b", valid_b, 4'b1000);

        // Clear with save to slot 3.
        idle(); ckpt_clear = 1'b1; ckpt_save = 1'b1; ckpt_save_idx = 2'd3;
        tick();
        chk("clear_save_valid_a", valid_a, 4'b1000);
        chk("clear_save_valid_b", valid_b, 4'b1000);
        chk("clear_oor_valid_c", valid_c, 3'b000);
        chk("clear_oor_err_c", err_c, 1'b1);

        // Reset during a restore cycle.
        idle(); resetn = 1'b0; ckpt_restore = 1'b1; ckpt_restore_idx = 2'd3;
        tick();
        chk("rst_restore_q_a", q_a, 8'hA5);
        chk("rst_restore_valid_a", valid_a, 4'b0000);
        chk("rst_restore_err_a", err_a, 1'b0);

        // First restore after reset hits an invalid slot.
        resetn = 1'b1;
        tick();
        chk("post_rst_err_a", err_a, 1'b1);
        chk("post_rst_q_a", q_a, 8'hA5);

        idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
